// File: rtl/eei_pkg.sv
// Shared execution-environment constants: memory-map window of the ACLINT,
// bus widths and the byte-masked merge used by every 64-bit register.
package eei;
  localparam int XLEN              = 64;
  localparam int MEMBUS_DATA_WIDTH = 64;
  localparam int MAX_HARTS         = 64;

  typedef logic [63:0] UInt64;
  typedef logic [31:0] UInt32;

  localparam UInt64 MMAP_ACLINT_BEGIN    = 64'h0000_0000_0200_0000;
  localparam UInt64 MMAP_ACLINT_END      = MMAP_ACLINT_BEGIN + 64'h0000_0000_0000_BFFF;
  localparam UInt64 MMAP_ACLINT_MSIP     = 64'h0000_0000_0000_0000;
  localparam UInt64 MMAP_ACLINT_MTIMECMP = 64'h0000_0000_0000_4000;
  localparam UInt64 MMAP_ACLINT_MTIME    = 64'h0000_0000_0000_7FF8;
  localparam UInt64 MMAP_ACLINT_SETSSIP  = 64'h0000_0000_0000_8000;

  function automatic UInt64 apply_wmask(input UInt64 old_val, input UInt64 new_val,
                                        input logic [MEMBUS_DATA_WIDTH/8-1:0] wmask);
    UInt64 res;
    res = old_val;
    for (int b = 0; b < MEMBUS_DATA_WIDTH / 8; b++) begin
      if (wmask[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction
endpackage

// File: rtl/aclint_harts_mtime.sv
// Shared MTIME counter with a TICK_DIV prescaler; a bus write (masked bytes)
// replaces the increment for that cycle and restarts the prescaler.
module aclint_mtime
  import eei::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en_i,
  input  UInt64                          wr_data_i,
  input  logic [MEMBUS_DATA_WIDTH/8-1:0] wr_mask_i,
  input  logic                           inc_suppress_i,
  output UInt64                          mtime_o
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  UInt64         mtime_q, mtime_d;

  always_comb begin
    presc_d = presc_q;
    mtime_d = mtime_q;
    if (inc_suppress_i) begin
      presc_d = '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      mtime_d = mtime_q + 64'd1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
    // Unmasked bytes keep the old (non-incremented) value.
    if (wr_en_i) mtime_d = apply_wmask(mtime_q, wr_data_i, wr_mask_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

  assign mtime_o = mtime_q;
endmodule

// File: rtl/aclint_harts.sv
// Multi-hart ACLINT: bus decode, per-hart MSIP/MTIMECMP/SETSSIP state,
// registered timer compare and a one-cycle response register.
module aclint_harts
  import eei::*;
#(
  parameter int NUM_HARTS = 1,
  parameter int TICK_DIV  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           bus_valid,
  output logic                           bus_ready,
  input  logic [XLEN-1:0]                bus_addr,
  input  logic                           bus_wen,
  input  logic [MEMBUS_DATA_WIDTH-1:0]   bus_wdata,
  input  logic [MEMBUS_DATA_WIDTH/8-1:0] bus_wmask,
  output logic                           bus_rvalid,
  output logic [MEMBUS_DATA_WIDTH-1:0]   bus_rdata,
  output logic [NUM_HARTS-1:0]           msip,
  output logic [NUM_HARTS-1:0]           mtip,
  output logic [NUM_HARTS-1:0]           ssip_set
);
  UInt64                beat_addr;
  logic                 in_window;
  logic                 wr_acc;
  logic                 mtime_hit;
  logic                 unused_addr_lo;
  UInt64                mtime;
  logic [NUM_HARTS-1:0] msip_hit, cmp_hit, ssip_hit;
  UInt64                cmp_val [NUM_HARTS];
  logic                 rvalid_q;
  UInt64                rdata_q, rdata_d;

  assign beat_addr      = {bus_addr[XLEN-1:3], 3'b000};
  assign unused_addr_lo = ^bus_addr[2:0];
  assign in_window      = bus_addr < (MMAP_ACLINT_END - MMAP_ACLINT_BEGIN + 64'd1);
  assign wr_acc         = bus_valid & bus_wen & in_window;
  assign mtime_hit      = in_window & (beat_addr == MMAP_ACLINT_MTIME);
  assign bus_ready      = 1'b1;

  aclint_mtime #(.TICK_DIV(TICK_DIV)) u_mtime (
    .clk            (clk),
    .rst            (rst),
    .wr_en_i        (wr_acc & mtime_hit),
    .wr_data_i      (bus_wdata),
    .wr_mask_i      (bus_wmask),
    .inc_suppress_i (wr_acc & mtime_hit),
    .mtime_o        (mtime)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
      // Even harts live in the low word of a beat, odd harts in the high word.
      localparam int LANE = 32 * (gi % 2);
      localparam int MB   = 4 * (gi % 2);

      logic  lane_bit0;
      logic  msip_q, msip_d, mtip_q, ssip_q, ssip_d;
      UInt64 cmp_q, cmp_d;

      assign lane_bit0     = bus_wdata[LANE];
      assign msip_hit[gi]  = in_window & (beat_addr == MMAP_ACLINT_MSIP + UInt64'(8 * (gi / 2)));
      assign cmp_hit[gi]   = in_window & (beat_addr == MMAP_ACLINT_MTIMECMP + UInt64'(8 * gi));
      assign ssip_hit[gi]  = in_window & (beat_addr == MMAP_ACLINT_SETSSIP + UInt64'(8 * (gi / 2)));

      always_comb begin
        msip_d = msip_q;
        cmp_d  = cmp_q;
        if (wr_acc & msip_hit[gi] & bus_wmask[MB]) msip_d = lane_bit0;
        if (wr_acc & cmp_hit[gi]) cmp_d = apply_wmask(cmp_q, bus_wdata, bus_wmask);
        ssip_d = wr_acc & ssip_hit[gi] & bus_wmask[MB] & lane_bit0;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          msip_q <= 1'b0;
          cmp_q  <= '1;
          mtip_q <= 1'b0;
          ssip_q <= 1'b0;
        end else begin
          msip_q <= msip_d;
          cmp_q  <= cmp_d;
          mtip_q <= (mtime >= cmp_q);
          ssip_q <= ssip_d;
        end
      end

      assign msip[gi]     = msip_q;
      assign mtip[gi]     = mtip_q;
      assign ssip_set[gi] = ssip_q;
      assign cmp_val[gi]  = cmp_q;
    end
  endgenerate

  // Read data reflects state before any write accepted in the same cycle.
  always_comb begin
    rdata_d = '0;
    if (mtime_hit) rdata_d = mtime;
    for (int i = 0; i < NUM_HARTS; i++) begin
      if (msip_hit[i]) rdata_d[32*(i%2)] = msip[i];
      if (cmp_hit[i]) rdata_d = cmp_val[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= bus_valid;
      if (bus_valid) rdata_q <= rdata_d;
    end
  end

  assign bus_rvalid = rvalid_q;
  assign bus_rdata  = rdata_q;
endmodule

// File: tb/tb_aclint_harts.sv
// Bench for aclint_harts: table vectors, hand-written timing sequences and a
// randomized run checked against a cycle-indexed arithmetic model.
module tb_aclint_harts;
  import eei::*;

  localparam int NH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       sel = 1'b0;
  logic       bus_valid = 1'b0;
  UInt64      bus_addr = '0;
  logic       bus_wen = 1'b0;
  UInt64      bus_wdata = '0;
  logic [7:0] bus_wmask = '0;

  logic          ready1, rv1;
  UInt64         rd1;
  logic [NH-1:0] msip1, mtip1, ssip1;
  logic          ready3, rv3;
  UInt64         rd3;
  logic [0:0]    msip3, mtip3, ssip3;

  aclint_harts #(.NUM_HARTS(NH), .TICK_DIV(1)) dut (
    .clk(clk), .rst(rst), .bus_valid(bus_valid & ~sel), .bus_ready(ready1),
    .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_rvalid(rv1), .bus_rdata(rd1), .msip(msip1), .mtip(mtip1), .ssip_set(ssip1)
  );

  aclint_harts #(.NUM_HARTS(1), .TICK_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .bus_valid(bus_valid & sel), .bus_ready(ready3),
    .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_rvalid(rv3), .bus_rdata(rd3), .msip(msip3), .mtip(mtip3), .ssip_set(ssip3)
  );

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input UInt64 act, input UInt64 exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic req(input UInt64 addr, input logic wen, input UInt64 wdata,
                     input logic [7:0] wmask, output UInt64 rdata);
    bus_addr = addr; bus_wen = wen; bus_wdata = wdata; bus_wmask = wmask;
    bus_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_valid = 1'b0;
    chk("rvalid", UInt64'(sel ? rv3 : rv1), 64'd1);
    rdata = sel ? rd3 : rd1;
    $display("txn dut=%0d addr=%h wen=%0d wdata=%h wmask=%h rdata=%h msip=%b mtip=%b ssip=%b",
             sel ? 3 : 1, addr, wen, wdata, wmask, rdata, msip1, mtip1, ssip1);
  endtask

  // Reference model: MTIME as base + elapsed cycles, registers as plain arrays.
  UInt64  m_base;
  longint m_base_cyc;
  logic   m_msip [NH];
  UInt64  m_cmp  [NH];

  function automatic UInt64 merge(input UInt64 o, input UInt64 n, input logic [7:0] m);
    UInt64 r = o;
    for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic UInt64 m_mtime(input longint k);
    return m_base + UInt64'(k - m_base_cyc);
  endfunction

  function automatic UInt64 m_read(input UInt64 addr, input longint k);
    UInt64 off = addr & ~64'h7;
    UInt64 r = '0;
    if (off == 64'h7FF8) r = m_mtime(k);
    else if (off < 64'h4000) begin
      for (int w = 0; w < 2; w++) begin
        longint h = longint'(off >> 2) + w;
        if (h < NH) r[32*w] = m_msip[h];
      end
    end else if (off < 64'h4000 + 64'(8 * NH)) r = m_cmp[int'((off - 64'h4000) >> 3)];
    return r;
  endfunction

  task automatic m_write(input UInt64 addr, input UInt64 wdata, input logic [7:0] wmask,
                         input longint k, output logic [NH-1:0] ssip_exp);
    UInt64 off = addr & ~64'h7;
    ssip_exp = '0;
    if (off == 64'h7FF8) begin
      m_base     = merge(m_mtime(k - 1), wdata, wmask);
      m_base_cyc = k;
    end else if (off < 64'h4000) begin
      for (int w = 0; w < 2; w++) begin
        longint h = longint'(off >> 2) + w;
        if (h < NH && wmask[4*w]) m_msip[h] = wdata[32*w];
      end
    end else if (off < 64'h4000 + 64'(8 * NH)) begin
      int i = int'((off - 64'h4000) >> 3);
      m_cmp[i] = merge(m_cmp[i], wdata, wmask);
    end else if (off >= 64'h8000 && off < 64'hC000) begin
      for (int w = 0; w < 2; w++) begin
        longint h = longint'((off - 64'h8000) >> 2) + w;
        if (h < NH && wmask[4*w] && wdata[32*w]) ssip_exp[h] = 1'b1;
      end
    end
  endtask

  typedef struct {
    UInt64      addr;
    logic       wen;
    UInt64      wdata;
    logic [7:0] wmask;
    UInt64      exp_rd;
    logic [3:0] exp_msip;
  } vec_t;

  vec_t  tbl [13];
  UInt64 addr_list [18] = '{64'h0, 64'h8, 64'h10, 64'h4, 64'h4000, 64'h4008, 64'h4010,
                            64'h4018, 64'h4020, 64'h7FF8, 64'h7FFC, 64'h8000, 64'h8004,
                            64'h8008, 64'h8010, 64'h100, 64'hBFF8, 64'hC000};

  initial begin
    UInt64 rd, a, b;
    UInt32 lo_word;
    logic [NH-1:0] ssip_exp, mtip_exp, msip_exp;

    tbl[0]  = '{64'h4018, 1'b0, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000};
    tbl[1]  = '{64'h8, 1'b1, 64'h0000_0001_0000_0001, 8'hF0, 64'h0, 4'b1000};
    tbl[2]  = '{64'h8, 1'b0, 64'h0, 8'h00, 64'h0000_0001_0000_0000, 4'b1000};
    tbl[3]  = '{64'h10, 1'b1, 64'h1, 8'hFF, 64'h0, 4'b1000};
    tbl[4]  = '{64'h10, 1'b0, 64'h0, 8'h00, 64'h0, 4'b1000};
    tbl[5]  = '{64'h0, 1'b1, 64'h0000_0001_0000_0001, 8'h11, 64'h0, 4'b1011};
    tbl[6]  = '{64'h0, 1'b0, 64'h0, 8'h00, 64'h0000_0001_0000_0001, 4'b1011};
    tbl[7]  = '{64'h0, 1'b1, 64'h0, 8'hEE, 64'h0000_0001_0000_0001, 4'b1011};
    tbl[8]  = '{64'h4008, 1'b1, 64'h1234, 8'h03, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1011};
    tbl[9]  = '{64'h4008, 1'b0, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_1234, 4'b1011};
    tbl[10] = '{64'h8000, 1'b0, 64'h0, 8'h00, 64'h0, 4'b1011};
    tbl[11] = '{64'h100, 1'b0, 64'h0, 8'h00, 64'h0, 4'b1011};
    tbl[12] = '{64'hC000, 1'b0, 64'h0, 8'h00, 64'h0, 4'b1011};

    // Reset state of both instances.
    do_reset();
    chk("rst_mtip", UInt64'(mtip1), 64'd0);
    chk("rst_msip", UInt64'(msip1), 64'd0);
    chk("rst_ssip", UInt64'(ssip1), 64'd0);
    chk("rst_rvalid", UInt64'(rv1), 64'd0);
    chk("rst_rdata", rd1, 64'd0);
    chk("ready", UInt64'(ready1), 64'd1);
    chk("ready3", UInt64'(ready3), 64'd1);
    chk("rst3_outs", UInt64'({rv3, msip3, mtip3, ssip3}), 64'd0);

    for (int i = 0; i < 13; i++) begin
      req(tbl[i].addr, tbl[i].wen, tbl[i].wdata, tbl[i].wmask, rd);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_msip", i), UInt64'(msip1), UInt64'(tbl[i].exp_msip));
    end

    // MTIME advances by one per clock with TICK_DIV = 1.
    req(64'h7FF8, 1'b0, 64'h0, 8'h00, a);
    step(4);
    req(64'h7FF8, 1'b0, 64'h0, 8'h00, b);
    chk("mtime_delta5", b - a, 64'd5);

    // Timer compare for hart 2.
    do_reset();
    req(64'h4010, 1'b1, 64'h40, 8'hFF, rd);
    req(64'h7FF8, 1'b1, 64'h3E, 8'hFF, rd);
    chk("mtip_e0", UInt64'(mtip1), 64'd0);
    step(2);
    chk("mtip_e2", UInt64'(mtip1), 64'd0);
    step(1);
    chk("mtip_rise", UInt64'(mtip1), 64'h4);
    req(64'h4010, 1'b1, 64'h1000, 8'hFF, rd);
    chk("mtip_hold", UInt64'(mtip1), 64'h4);
    step(1);
    chk("mtip_clear", UInt64'(mtip1), 64'd0);
    chk("rvalid_idle", UInt64'(rv1), 64'd0);

    // SETSSIP pulse for hart 1.
    req(64'h8004, 1'b1, 64'h0000_0001_0000_0000, 8'hF0, rd);
    chk("ssip_pulse", UInt64'(ssip1), 64'h2);
    req(64'h8000, 1'b0, 64'h0, 8'h00, rd);
    chk("ssip_drop", UInt64'(ssip1), 64'd0);
    chk("setssip_rd", rd, 64'd0);

    // Reset with a request in flight drops the response.
    bus_addr = 64'h4018; bus_wen = 1'b0; bus_valid = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    bus_valid = 1'b0; rst = 1'b0;
    chk("rst_inflight_rvalid", UInt64'(rv1), 64'd0);

    // Prescaled MTIME with a masked write landing on a tick cycle.
    sel = 1'b1;
    do_reset();
    req(64'h7FF8, 1'b1, 64'h10, 8'hFF, rd);
    step(2);
    req(64'h7FF8, 1'b1, 64'hFFFF_FFFF_FFFF_FFAB, 8'h01, rd);
    chk("presc_prewrite", rd, 64'h10);
    for (int i = 0; i < 4; i++) begin
      req(64'h7FF8, 1'b0, 64'h0, 8'h00, rd);
      chk($sformatf("presc_rd%0d", i), rd, (i < 3) ? 64'hAB : 64'hAC);
    end
    sel = 1'b0;

    // Randomized traffic against the model.
    do_reset();
    m_base = '0;
    m_base_cyc = cyc;
    for (int h = 0; h < NH; h++) begin
      m_msip[h] = 1'b0;
      m_cmp[h]  = '1;
    end
    for (int n = 0; n < 80; n++) begin
      UInt64 addr, wdata, exp_rd;
      logic wen;
      logic [7:0] wmask;
      longint c;
      addr    = addr_list[$urandom_range(0, 17)];
      wen     = 1'($urandom_range(0, 1));
      lo_word = $urandom;
      wdata   = ($urandom_range(0, 1) == 1) ? {$urandom, lo_word} : UInt64'($urandom_range(0, 300));
      wmask   = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      c       = cyc;
      exp_rd  = m_read(addr, c);
      for (int h = 0; h < NH; h++) mtip_exp[h] = (m_mtime(c) >= m_cmp[h]);
      ssip_exp = '0;
      if (wen) m_write(addr, wdata, wmask, c + 1, ssip_exp);
      for (int h = 0; h < NH; h++) msip_exp[h] = m_msip[h];
      req(addr, wen, wdata, wmask, rd);
      chk("rnd_rdata", rd, exp_rd);
      chk("rnd_msip", UInt64'(msip1), UInt64'(msip_exp));
      chk("rnd_mtip", UInt64'(mtip1), UInt64'(mtip_exp));
      chk("rnd_ssip", UInt64'(ssip1), UInt64'(ssip_exp));
      if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aclint_harts.md
# aclint_harts

Parametrised ACLINT: one shared 64-bit MTIME counter plus per-hart MSIP, MTIMECMP and SETSSIP registers for NUM_HARTS harts, reached over the 64-bit memory bus at the ACLINT window (base 0x200_0000, size 0xC000). It drives per-hart machine software, machine timer and supervisor software interrupt lines into each core's CSR unit. It generalises the single-hart register map to N harts, adds a programmable MTIME prescaler and provides byte-masked 64-bit access.

## Interface
- NUM_HARTS, 1: number of harts; 1..64.
- TICK_DIV, 1: MTIME increments once every TICK_DIV clocks; 1 means every clock.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- bus_valid  in  1  request valid.
- bus_ready  out  1  request accepted; constant 1.
- bus_addr  in  XLEN  byte offset from the ACLINT base; bits [2:0] ignored.
- bus_wen  in  1  1 = write, 0 = read.
- bus_wdata  in  MEMBUS_DATA_WIDTH  write data.
- bus_wmask  in  MEMBUS_DATA_WIDTH/8  byte enables for writes.
- bus_rvalid  out  1  read/write response, one cycle after acceptance.
- bus_rdata  out  MEMBUS_DATA_WIDTH  read data; valid while bus_rvalid is 1.
- msip  out  NUM_HARTS  machine software interrupt pending, per hart.
- mtip  out  NUM_HARTS  machine timer interrupt pending, per hart.
- ssip_set  out  NUM_HARTS  one-cycle pulse that sets mip.SSIP, per hart.

## Operation
- Register map, as offsets from the base. Any offset not listed reads 0 and ignores writes.
  - MSIP[h] at 0x0000 + 4h: 32 bits; only bit 0 is stored.
  - MTIMECMP[h] at 0x4000 + 8h: 64 bits.
  - MTIME at 0x7FF8: 64 bits.
  - SETSSIP[h] at 0x8000 + 4h: 32 bits; always reads 0.
- Valid hart range is h < NUM_HARTS. Offsets for h ≥ NUM_HARTS are treated as unmapped.
- 32-bit registers packed into a 64-bit beat:
  - The low word (bytes 0-3) is hart 2k; the high word (bytes 4-7) is hart 2k+1.
  - A word is written only if its wmask byte 0 (bit 0 or bit 4) is set; the other mask bits of that word are ignored.
- 64-bit registers: byte-granular writes under bus_wmask.
- SETSSIP write with bit 0 = 1 pulses ssip_set[h] high for exactly one cycle. Writing 0 has no effect.
- MTIME counter:
  - A prescaler counts 0..TICK_DIV-1.
  - MTIME increments by 1 when the prescaler wraps, and wraps from 2^64-1 to 0.
  - A bus write to MTIME in the same cycle wins over the increment: the masked bytes take the written value, the unmasked bytes keep the old value and are not incremented. The prescaler resets to 0.
- mtip[h] is a registered result of MTIME ≥ MTIMECMP[h], compared unsigned.
- msip[h] mirrors stored MSIP[h] bit 0.
- Reset values:
  - MTIME = 0; prescaler = 0.
  - MTIMECMP[*] = all ones.
  - MSIP[*] = 0.
  - bus_rvalid = 0, bus_rdata = 0.
  - mtip = 0, msip = 0, ssip_set = 0.
- Reset while a request is in flight: the response is dropped and bus_rvalid is 0 the next cycle.

## Timing
- bus_ready is always 1. A request is accepted in every cycle where bus_valid is 1; back-to-back requests are supported.
- Response latency:
  - bus_rvalid is 1 exactly one cycle after each accepted request, writes included.
  - bus_rdata is the register value before any write in the accepting cycle.
- Register updates:
  - Written registers update at the clock edge that ends the accepting cycle.
  - msip follows one cycle after the write.
  - ssip_set pulses in the cycle after the write.
  - mtip reflects the new MTIMECMP or MTIME one cycle after the register update, i.e. two cycles after acceptance.
- MTIME read returns the pre-increment value of the accepting cycle.
- MTIME increments with TICK_DIV = 1 produce a strictly +1-per-cycle sequence; with TICK_DIV = 3, MTIME is held for 3 cycles per step.

## Structure
- Shared in package eei:
  - MMAP_ACLINT_* constants, including MMAP_ACLINT_BEGIN/END, MSIP, MTIMECMP, MTIME, SETSSIP.
  - MEMBUS_DATA_WIDTH.
  - UInt64, UInt32.
- New in eei: MAX_HARTS = 64.
- Sub-module aclint_mtime: the prescaler plus MTIME counter, with a masked write port and an increment-suppress input. It exposes the current MTIME value.
- Everything else (decode, per-hart arrays, compare registers, response register) lives in aclint_harts.

## Test plan
- Reset, NUM_HARTS = 4, TICK_DIV = 1:
  - After rst, mtip = 0, msip = 0, ssip_set = 0.
  - Reading 0x4018 returns 0xFFFF_FFFF_FFFF_FFFF.
  - Two MTIME reads 5 cycles apart differ by 5.
- Timer:
  - Write MTIMECMP[2] = 0x40 at 0x4010, then write MTIME = 0x3E.
  - mtip[2] rises when MTIME reaches 0x40; other mtip bits stay 0.
  - Writing MTIMECMP[2] = 0x1000 clears mtip[2] two cycles after acceptance.
- Packed MSIP:
  - Write 0x0000_0001_0000_0001 to offset 0x8 with wmask 0xF0.
  - Only msip[3] = 1; msip[2] = 0.
  - Reading 0x8 returns 0x0000_0001_0000_0000.
- SETSSIP:
  - Write 1 to 0x8004 (hart 1).
  - ssip_set[1] is high for exactly one cycle; a read of 0x8000 returns 0.
- MTIME masked write plus prescaler, TICK_DIV = 3:
  - With MTIME = 0x10, write 0xAB with wmask 0x01 in a tick cycle.
  - MTIME = 0xAB with no increment, then MTIME = 0xAC three cycles later.
- Out of range:
  - Write 1 to MSIP at 0x10 (hart 4) with NUM_HARTS = 4.
  - No msip change; a read returns 0 and bus_rvalid still pulses.
